step_display_ctrl: RTL

- Board-level front end for the 5-stage MIPS pipeline.
- Upstream of the CPU, it turns a bouncy push-button into a clean single-step clock (`step_clk`) for the pipeline.
- Downstream of the CPU, it consumes the PC and one selected register value and drives a 4-digit multiplexed seven-segment display.
- `reg_sel` goes to the register-view mux in the top level; `reg_in` returns the selected value.

---
 rtl/display_pkg.sv | 16 +
 rtl/step_display_ctrl_if.sv | 27 ++
 rtl/btn_debounce.sv | 31 +++
 rtl/step_display_ctrl.sv | 102 ++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: step-FSM state encoding and seven-segment constants shared by step_display_ctrl.
package display_pkg;
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        HIGH         = 2'd1,
        WAIT_RELEASE = 2'd2
    } stepState_t;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
endpackage

// File: rtl/step_display_ctrl_if.sv
// step_display_ctrl_if: board/CPU-side signals of the step and display front end.
// sw_auto exists only when STEP_AUTO_RUN_EN is defined.
interface step_display_ctrl_if;
    logic        btn_step;
    logic [4:0]  sw_sel;
    logic        sw_mode;
    logic        sw_half;
    logic [31:0] pc_in;
    logic [31:0] reg_in;
    logic [4:0]  reg_sel;
    logic        step_clk;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic        dp;
`ifdef STEP_AUTO_RUN_EN
    logic        sw_auto;
    modport master (output btn_step, sw_sel, sw_mode, sw_half, pc_in, reg_in, sw_auto,
                    input reg_sel, step_clk, anode, cathode, dp);
    modport slave  (input btn_step, sw_sel, sw_mode, sw_half, pc_in, reg_in, sw_auto,
                    output reg_sel, step_clk, anode, cathode, dp);
`else
    modport master (output btn_step, sw_sel, sw_mode, sw_half, pc_in, reg_in,
                    input reg_sel, step_clk, anode, cathode, dp);
    modport slave  (input btn_step, sw_sel, sw_mode, sw_half, pc_in, reg_in,
                    output reg_sel, step_clk, anode, cathode, dp);
`endif
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer plus stability counter; the level follows the input
// only after it has held a new value for DEBOUNCE_CYCLES clocks.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btnRaw,
    output logic btnLevel
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    logic sync1, sync2;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            cnt      <= '0;
            btnLevel <= 1'b0;
        end else begin
            sync1 <= btnRaw;
            sync2 <= sync1;
            if (sync2 == btnLevel)
                cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                btnLevel <= sync2;
                cnt      <= '0;
            end else
                cnt <= cnt + CW'(1);
        end
endmodule

// File: rtl/step_display_ctrl.sv
// step_display_ctrl: debounced single-step clock for the pipeline and a 4-digit hex PC/register display.
// Define STEP_AUTO_RUN_EN to add the sw_auto periodic step generator.
module step_display_ctrl
    import display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 1000000,
    parameter int SCAN_CYCLES      = 50000,
    parameter int STEP_HIGH_CYCLES = 4,
    parameter int AUTO_PERIOD      = 25000000
) (
    input logic clk,
    input logic reset,
    step_display_ctrl_if.slave bus
);
    localparam int HW = $clog2(STEP_HIGH_CYCLES) + 1;
    localparam int SW = $clog2(SCAN_CYCLES) + 1;

    if (DEBOUNCE_CYCLES < 1 || SCAN_CYCLES < 1 || STEP_HIGH_CYCLES < 1 || AUTO_PERIOD < 1) begin : g_badParams
        $error("step_display_ctrl: timing parameters must be at least 1");
    end

    stepState_t state, stateNext;
    logic [HW-1:0] highCnt;
    logic btnLevel, autoTick, stepTrig;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk(clk),
        .reset(reset),
        .btnRaw(bus.btn_step),
        .btnLevel(btnLevel)
    );

`ifdef STEP_AUTO_RUN_EN
    localparam int AW = $clog2(AUTO_PERIOD) + 1;
    logic [AW-1:0] autoCnt;
    assign autoTick = bus.sw_auto && autoCnt == AW'(AUTO_PERIOD - 1);
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            autoCnt <= '0;
        else
            autoCnt <= (!bus.sw_auto || autoTick) ? '0 : autoCnt + AW'(1);
`else
    assign autoTick = 1'b0;
`endif

    // IDLE is only re-entered with the level low, so a high level seen in IDLE is a fresh press.
    assign stepTrig = btnLevel || autoTick;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state   <= IDLE;
            highCnt <= '0;
        end else begin
            state   <= stateNext;
            highCnt <= (state == HIGH) ? highCnt + HW'(1) : '0;
        end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:         if (stepTrig) stateNext = HIGH;
            HIGH:         if (highCnt == HW'(STEP_HIGH_CYCLES - 1)) stateNext = WAIT_RELEASE;
            WAIT_RELEASE: if (!btnLevel) stateNext = IDLE;
            default:      stateNext = IDLE;
        endcase
    end

    always_comb bus.step_clk = (state == HIGH);

    logic [SW-1:0] scanCnt;
    logic [1:0] digit, digitNext;
    logic [15:0] dispVal, dispNext;
    logic [31:0] viewVal;
    logic scanWrap;

    // The shown value only changes on the digit 3 -> 0 wrap, so a frame never mixes two values.
    always_comb begin
        viewVal   = bus.sw_mode ? bus.reg_in : bus.pc_in;
        scanWrap  = scanCnt == SW'(SCAN_CYCLES - 1);
        digitNext = scanWrap ? digit + 2'd1 : digit;
        dispNext  = (scanWrap && digit == 2'd3) ? (bus.sw_half ? viewVal[31:16] : viewVal[15:0]) : dispVal;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            scanCnt     <= '0;
            digit       <= '0;
            dispVal     <= '0;
            bus.reg_sel <= '0;
            bus.anode   <= 4'b1110;
            bus.cathode <= HEX_SEG[0];
            bus.dp      <= 1'b1;
        end else begin
            scanCnt     <= scanWrap ? '0 : scanCnt + SW'(1);
            digit       <= digitNext;
            dispVal     <= dispNext;
            bus.reg_sel <= bus.sw_sel;
            bus.anode   <= ~(4'b0001 << digitNext);
            bus.cathode <= HEX_SEG[dispNext[{digitNext, 2'b00} +: 4]];
            bus.dp      <= !(bus.sw_mode && digitNext == 2'd3);
        end
endmodule
